// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access sequencer: size codes, trap codes,
// FSM states and the alignment rule.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'd0,
      SZ_HALF   = 2'd1,
      SZ_WORD   = 2'd2,
      SZ_DOUBLE = 2'd3
   } size_e;

   localparam logic [2:0] TT_NONE    = 3'd0;
   localparam logic [2:0] TT_ALIGN   = 3'd5;
   localparam logic [2:0] TT_TIMEOUT = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACC0 = 3'd1,
      S_GAP  = 3'd2,
      S_ACC1 = 3'd3,
      S_RESP = 3'd4
   } state_e;

   // Natural alignment: half on 2, word on 4, double on 8 bytes.
   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lsb);
      case (size)
         SZ_HALF:   return (lsb[0] == 1'b0);
         SZ_WORD:   return (lsb[1:0] == 2'b00);
         SZ_DOUBLE: return (lsb == 3'b000);
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extender.sv
// Combinational size/sign extension of right-aligned RAM read data.
module load_extender
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   // Byte and half are truncated then extended; word/double pass through.
   always_comb begin
      dout = din;
      case (size)
         SZ_BYTE: dout = {{(DATA_W-8){sign_ext & din[7]}}, din[7:0]};
         SZ_HALF: dout = {{(DATA_W-16){sign_ext & din[15]}}, din[15:0]};
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: byte/half/word/double loads and stores over a
// single-beat MFC handshake, with alignment check and bounded MFC wait.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              req,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wdata_hi,
   output logic              busy,
   output logic              done,
   output logic              trap,
   output logic [2:0]        tt,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] rdata_hi,
   output logic              mem_en,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              MFC
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   state_e              state;
   logic [CNT_W-1:0]    wait_cnt;
   logic                we_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_hi_q;
   logic [DATA_W-1:0]   ext_data;

   load_extender #(.DATA_W(DATA_W)) u_ext (
      .size     (size_q),
      .sign_ext (signed_q),
      .din      (mem_rdata),
      .dout     (ext_data)
   );

   // Status and RAM enable decode from the state register alone.
   assign busy   = (state != S_IDLE);
   assign done   = (state == S_RESP);
   assign mem_en = (state == S_ACC0) || (state == S_ACC1);

   // Sequencer FSM; RAM address/data/size are set up on the edge entering each beat.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         trap       <= 1'b0;
         tt         <= TT_NONE;
         rdata      <= '0;
         rdata_hi   <= '0;
         mem_we     <= 1'b0;
         mem_size   <= 2'd0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         addr_q     <= '0;
         wdata_hi_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  we_q       <= req_we;
                  size_q     <= req_size;
                  signed_q   <= req_signed;
                  addr_q     <= req_addr;
                  wdata_hi_q <= req_wdata_hi;
                  wait_cnt   <= '0;
                  if (!is_aligned(req_size, req_addr[2:0])) begin
                     state <= S_RESP;
                     trap  <= 1'b1;
                     tt    <= TT_ALIGN;
                  end else begin
                     state     <= S_ACC0;
                     mem_we    <= req_we;
                     mem_size  <= (req_size == SZ_DOUBLE) ? 2'(SZ_WORD) : req_size;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                  end
               end
            end
            S_ACC0: begin
               if (MFC) begin
                  if (!we_q) rdata <= ext_data;
                  state <= (size_q == SZ_DOUBLE) ? S_GAP : S_RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  state <= S_RESP;
                  trap  <= 1'b1;
                  tt    <= TT_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_GAP: begin
               state     <= S_ACC1;
               wait_cnt  <= '0;
               mem_addr  <= addr_q + ADDR_W'(4);
               mem_wdata <= wdata_hi_q;
            end
            S_ACC1: begin
               if (MFC) begin
                  if (!we_q) rdata_hi <= mem_rdata;
                  state <= S_RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  state <= S_RESP;
                  trap  <= 1'b1;
                  tt    <= TT_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               trap  <= 1'b0;
               tt    <= TT_NONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 8;

   logic              Clk = 1'b0;
   logic              Clr = 1'b1;
   logic              req = 1'b0;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'd0;
   logic              req_signed = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic [DATA_W-1:0] req_wdata_hi = '0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              MFC = 1'b0;
   logic              busy, done, trap, mem_en, mem_we;
   logic [2:0]        tt;
   logic [DATA_W-1:0] rdata, rdata_hi, mem_wdata;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .Clk(Clk), .Clr(Clr), .req(req), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wdata_hi(req_wdata_hi), .busy(busy), .done(done), .trap(trap), .tt(tt),
      .rdata(rdata), .rdata_hi(rdata_hi), .mem_en(mem_en), .mem_we(mem_we),
      .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .MFC(MFC)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_rdata = 0;
   logic [31:0] m_rdata_hi = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ext_ref(input logic [1:0] sz, input bit sg, input logic [31:0] v);
      logic [31:0] r;
      if (sz == 2'd0) begin
         r = v % 256;
         if (sg && r >= 128) r = r + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         r = v % 65536;
         if (sg && r >= 32768) r = r + 32'hFFFF_0000;
      end else begin
         r = v;
      end
      return r;
   endfunction

   task automatic scramble_req();
      req          = 1'($urandom);
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_signed   = 1'($urandom);
      req_addr     = ADDR_W'($urandom);
      req_wdata    = $urandom;
      req_wdata_hi = $urandom;
   endtask

   // One request; d0/d1 = wait cycles before MFC in each beat (>= MAX_WAIT times out).
   task automatic run_txn(input string nm, input bit we, input logic [1:0] sz, input bit sg,
                          input int addr, input logic [31:0] wd, input logic [31:0] wdh,
                          input int d0, input int d1, input logic [31:0] rd0, input logic [31:0] rd1);
      bit aligned, seen;
      int lat, beats_exp, beats, w, dcur;
      bit exp_trap;
      logic [2:0] exp_tt;
      logic [31:0] rcur;
      bit in_beat;

      aligned = (sz == 0) || (sz == 1 && addr % 2 == 0) || (sz == 2 && addr % 4 == 0) ||
                (sz == 3 && addr % 8 == 0);
      exp_trap = 0; exp_tt = 3'd0;
      if (!aligned) begin
         lat = 1; beats_exp = 0; exp_trap = 1; exp_tt = 3'd5;
      end else if (d0 >= MAX_WAIT) begin
         lat = MAX_WAIT + 1; beats_exp = 1; exp_trap = 1; exp_tt = 3'd6;
      end else if (sz != 3) begin
         lat = d0 + 2; beats_exp = 1;
         if (!we) m_rdata = ext_ref(sz, sg, rd0);
      end else begin
         beats_exp = 2;
         if (!we) m_rdata = rd0;
         if (d1 >= MAX_WAIT) begin
            lat = d0 + MAX_WAIT + 3; exp_trap = 1; exp_tt = 3'd6;
         end else begin
            lat = d0 + d1 + 4;
            if (!we) m_rdata_hi = rd1;
         end
      end

      @(negedge Clk);
      req = 1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = ADDR_W'(addr); req_wdata = wd; req_wdata_hi = wdh;
      seen = 0; beats = 0; w = 0; in_beat = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge Clk);
         if (mem_en) begin
            if (!in_beat) begin
               beats++; w = 0; in_beat = 1;
               chk({nm, "_beat_we"}, 64'(mem_we), 64'(we));
               chk({nm, "_beat_size"}, 64'(mem_size), 64'((sz == 3) ? 2'd2 : sz));
               chk({nm, "_beat_addr"}, 64'(mem_addr),
                   64'((beats == 1) ? addr % 512 : (addr + 4) % 512));
               if (we) chk({nm, "_beat_wdata"}, 64'(mem_wdata), 64'((beats == 1) ? wd : wdh));
            end
            w++;
            dcur = (beats == 1) ? d0 : d1;
            rcur = (beats == 1) ? rd0 : rd1;
            MFC = (w == dcur + 1);
            mem_rdata = rcur;
         end else begin
            in_beat = 0;
            MFC = 1'($urandom);
            mem_rdata = $urandom;
         end
         if (done) begin
            seen = 1;
            chk({nm, "_lat"}, 64'(cyc), 64'(lat));
            chk({nm, "_trap"}, 64'(trap), 64'(exp_trap));
            chk({nm, "_tt"}, 64'(tt), 64'(exp_tt));
            chk({nm, "_rdata"}, 64'(rdata), 64'(m_rdata));
            chk({nm, "_rdata_hi"}, 64'(rdata_hi), 64'(m_rdata_hi));
            chk({nm, "_beats"}, 64'(beats), 64'(beats_exp));
            chk({nm, "_busy"}, 64'(busy), 64'd1);
            req = 0; MFC = 0;
            break;
         end
         scramble_req();
      end
      if (!seen) chk({nm, "_no_done"}, 64'd0, 64'd1);
      @(negedge Clk);
      chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
      chk({nm, "_idle_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      int ndone;
      repeat (3) @(negedge Clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_trap", 64'(trap), 0);
      chk("rst_tt", 64'(tt), 0);
      chk("rst_rdata", 64'(rdata), 0);
      chk("rst_rdata_hi", 64'(rdata_hi), 0);
      chk("rst_mem_en", 64'(mem_en), 0);
      chk("rst_mem_we", 64'(mem_we), 0);
      chk("rst_mem_size", 64'(mem_size), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_wdata", 64'(mem_wdata), 0);
      Clr = 0;

      run_txn("wload", 0, 2'd2, 0, 'h010, 0, 0, 0, 0, 32'hDEADBEEF, 0);
      run_txn("sbyte", 0, 2'd0, 1, 'h021, 0, 0, 0, 0, 32'h00000080, 0);
      run_txn("ubyte", 0, 2'd0, 0, 'h021, 0, 0, 0, 0, 32'h00000080, 0);
      run_txn("shalf", 0, 2'd1, 1, 'h0A2, 0, 0, 1, 0, 32'h1234_9ABC, 0);
      run_txn("dstore", 1, 2'd3, 0, 'h1F8, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0);
      run_txn("misalign", 0, 2'd2, 0, 'h013, 0, 0, 0, 0, 32'h5555_5555, 0);
      run_txn("tmo", 0, 2'd2, 0, 'h040, 0, 0, MAX_WAIT, 0, 32'h7777_7777, 0);
      run_txn("last_mfc", 0, 2'd2, 0, 'h040, 0, 0, MAX_WAIT - 1, 0, 32'hCAFE_F00D, 0);
      run_txn("dload_tmo1", 0, 2'd3, 0, 'h1F8, 0, 0, 0, MAX_WAIT, 32'hAAAA_0001, 32'hBBBB_0002);
      run_txn("dload_wrap", 0, 2'd3, 0, 'h1F8, 0, 0, 2, 3, 32'h0102_0304, 32'h0506_0708);

      // Clear during ACC1 of a double load aborts without a done pulse.
      @(negedge Clk);
      req = 1; req_we = 0; req_size = 2'd3; req_signed = 0; req_addr = 9'h100;
      @(negedge Clk);
      req = 0; MFC = 1; mem_rdata = 32'h0BAD_0BAD;
      @(negedge Clk);
      MFC = 0;
      @(negedge Clk);
      chk("clr_in_acc1", 64'(mem_en), 64'd1);
      Clr = 1;
      @(negedge Clk);
      Clr = 0;
      chk("clr_busy", 64'(busy), 0);
      chk("clr_mem_en", 64'(mem_en), 0);
      chk("clr_done", 64'(done), 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         MFC = 1'($urandom);
         @(negedge Clk);
         if (done) ndone++;
      end
      MFC = 0;
      chk("clr_no_done", 64'(ndone), 0);
      m_rdata = 0; m_rdata_hi = 0;
      chk("clr_rdata", 64'(rdata), 0);
      run_txn("after_clr", 0, 2'd2, 0, 'h104, 0, 0, 1, 0, 32'h600D_600D, 0);

      for (int n = 0; n < 150; n++) begin
         logic [1:0] sz;
         int addr, d0, d1;
         sz = 2'($urandom);
         addr = $urandom_range(0, 511);
         if ($urandom % 4 != 0) addr = addr - addr % ((sz == 3) ? 8 : (sz == 2) ? 4 : (sz == 1) ? 2 : 1);
         d0 = ($urandom % 4 == 0) ? $urandom_range(0, MAX_WAIT + 2) : $urandom_range(0, 2);
         d1 = ($urandom % 4 == 0) ? $urandom_range(0, MAX_WAIT + 2) : $urandom_range(0, 2);
         run_txn("rnd", 1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom,
                 d0, d1, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
